// File: rtl/bitonic_pkg.sv
// Shared types and constants for the bitonic sort pipeline.
package bitonic_pkg;

    localparam int unsigned DATA_W = 32;

    // B operand used to complete a pair when a block ends on an odd word.
    localparam logic [DATA_W-1:0] PAD_VALUE = {DATA_W{1'b1}};

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              dir;
        logic              last;
    } pair_t;

    typedef enum logic {
        StEmpty,
        StHold
    } feed_state_e;

endpackage

// File: rtl/bitonic_pair_fifo.sv
// Synchronous FIFO of operand pairs with fall-through read data.
module bitonic_pair_fifo
    import bitonic_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  pair_t wdata,
    input  logic  pop,
    output pair_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    pair_t            mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bitonic_pair_feeder.sv
// Groups a word stream into direction-tagged pairs and issues them to the
// compare-exchange element, tracking its one-cycle latency for res_valid.
module bitonic_pair_feeder #(
    parameter int unsigned       DATA_W     = bitonic_pkg::DATA_W,
    parameter int unsigned       DIR_PERIOD = 1,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] PAD_VALUE  = bitonic_pkg::PAD_VALUE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              m_stall,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              dir,
    output logic              enable,
    output logic              res_valid,
    output logic              res_last
);

    import bitonic_pkg::*;

    localparam int unsigned CntW = (DIR_PERIOD > 1) ? $clog2(DIR_PERIOD) : 1;

    feed_state_e       state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [CntW-1:0]   pair_cnt_q, pair_cnt_d;
    logic              cur_dir_q, cur_dir_d;
    logic              last_q;

    pair_t             push_pair;
    pair_t             pop_pair;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              xfer;

    // Ready is held low throughout reset so no word is taken mid-clear.
    assign s_ready = !rst && !fifo_full;
    assign xfer    = s_valid && s_ready;
    assign pop     = !fifo_empty && !m_stall;

    bitonic_pair_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_pair),
        .pop   (pop),
        .rdata (pop_pair),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pair assembly: hold the first word, push on the second or on a lone last.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        push      = 1'b0;
        push_pair = '0;
        case (state_q)
            StEmpty: begin
                if (xfer) begin
                    if (s_last) begin
                        push           = 1'b1;
                        push_pair.a    = s_data;
                        push_pair.b    = PAD_VALUE;
                        push_pair.last = 1'b1;
                    end else begin
                        hold_d  = s_data;
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (xfer) begin
                    push           = 1'b1;
                    push_pair.a    = hold_q;
                    push_pair.b    = s_data;
                    push_pair.last = s_last;
                    state_d        = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
        push_pair.dir = cur_dir_q;
    end

    // Direction counter: toggle every DIR_PERIOD pairs, restart ascending per block.
    always_comb begin
        pair_cnt_d = pair_cnt_q;
        cur_dir_d  = cur_dir_q;
        if (push) begin
            if (push_pair.last) begin
                pair_cnt_d = '0;
                cur_dir_d  = DIR_ASC;
            end else if (pair_cnt_q == CntW'(DIR_PERIOD - 1)) begin
                pair_cnt_d = '0;
                cur_dir_d  = !cur_dir_q;
            end else begin
                pair_cnt_d = pair_cnt_q + 1'b1;
            end
        end
    end

    // Assembly and direction state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StEmpty;
            hold_q     <= '0;
            pair_cnt_q <= '0;
            cur_dir_q  <= DIR_ASC;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            pair_cnt_q <= pair_cnt_d;
            cur_dir_q  <= cur_dir_d;
        end
    end

    // Issue registers plus the one-cycle result-tracking pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A         <= '0;
            B         <= '0;
            dir       <= DIR_ASC;
            last_q    <= 1'b0;
            enable    <= 1'b0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
        end else begin
            enable    <= pop;
            res_valid <= enable;
            res_last  <= enable && last_q;
            if (pop) begin
                A      <= pop_pair.a;
                B      <= pop_pair.b;
                dir    <= pop_pair.dir;
                last_q <= pop_pair.last;
            end
        end
    end

endmodule
